// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature sampler and the measurement FSM it drives.
package temp_pkg;

  localparam int WIDTH_DEF        = 10;
  localparam int PERIOD_W_DEF     = 16;
  localparam int AVG_MAX_LOG2_DEF = 3;
  localparam int TIMEOUT_DEF      = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACCUM,
    S_REPORT,
    S_WAIT_PERIOD
  } smp_state_e;

  // Measurement FSM states; done is high only in M_IDLE and M_DONE.
  typedef enum logic [1:0] {
    M_IDLE,
    M_CHARGE,
    M_COUNT,
    M_DONE
  } meas_state_e;

  function automatic logic [1:0] clamp_log2(input logic [1:0] req, input int max_log2);
    if (int'(req) > max_log2) return 2'(max_log2);
    return req;
  endfunction

endpackage

// File: rtl/temp_sampler_if.sv
// Measurement handshake plus published result bus between the sampler and its neighbours.
interface temp_sampler_if #(
  parameter int WIDTH = temp_pkg::WIDTH_DEF
);
  logic             start;
  logic             fsmDone;
  logic [WIDTH-1:0] cycles;
  logic [WIDTH-1:0] avg;
  logic             avgValid;
  logic             flagHigh;
  logic             flagLow;
  logic             error;

  modport master (
    output start, avg, avgValid, flagHigh, flagLow, error,
    input  fsmDone, cycles
  );

  modport slave (
    input  start, avg, avgValid, flagHigh, flagLow, error,
    output fsmDone, cycles
  );
endinterface

// File: rtl/temp_avg_acc.sv
// Accumulates conversion results, divides by the power-of-two sample count and keeps sticky threshold flags.
module temp_avg_acc
  import temp_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int AVG_MAX_LOG2 = AVG_MAX_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [1:0]       log2_i,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             report_i,
  input  logic [WIDTH-1:0] th_high_i,
  input  logic [WIDTH-1:0] th_low_i,
  input  logic             flag_clr_i,
  output logic             last_o,
  output logic [WIDTH-1:0] avg_o,
  output logic             avg_valid_o,
  output logic             flag_high_o,
  output logic             flag_low_o
);
  localparam int ACC_W = WIDTH + AVG_MAX_LOG2;
  localparam int CNT_W = 4;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target;
  logic [1:0]       log2_q, log2_d;
  logic [WIDTH-1:0] avg_q, avg_d, avg_new;
  logic             valid_q, valid_d;
  logic             high_q, high_d;
  logic             low_q, low_d;

  always_comb begin
    target  = CNT_W'(1) << log2_q;
    last_o  = (cnt_q + CNT_W'(1)) == target;
    avg_new = WIDTH'(acc_q >> log2_q);

    acc_d  = acc_q;
    cnt_d  = cnt_q;
    log2_d = log2_q;
    if (load_i) log2_d = log2_i;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (acc_i) begin
      acc_d = acc_q + ACC_W'(sample_i);
      cnt_d = cnt_q + CNT_W'(1);
    end

    avg_d   = report_i ? avg_new : avg_q;
    valid_d = report_i;
    // A set in the same cycle as a clear wins.
    high_d  = (report_i && (avg_new > th_high_i)) || (high_q && !flag_clr_i);
    low_d   = (report_i && (avg_new < th_low_i))  || (low_q  && !flag_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      log2_q  <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      high_q  <= 1'b0;
      low_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      log2_q  <= log2_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
      high_q  <= high_d;
      low_q   <= low_d;
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = valid_q;
  assign flag_high_o = high_q;
  assign flag_low_o  = low_q;

endmodule

// File: rtl/temp_sampler.sv
// Periodic scheduler for the temperature measurement FSM: issues start pulses, watches the done
// handshake with a timeout, and feeds results to the averager.
module temp_sampler
  import temp_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int PERIOD_W     = PERIOD_W_DEF,
  parameter int AVG_MAX_LOG2 = AVG_MAX_LOG2_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                lfClk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] interval,
  input  logic [1:0]          avgLog2,
  input  logic [WIDTH-1:0]    thHigh,
  input  logic [WIDTH-1:0]    thLow,
  input  logic                flagClr,
  temp_sampler_if.master      mif
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  smp_state_e          state_q, state_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                complete_q, complete_d;
  logic                error_q, error_d;

  logic start_w;
  logic clr_w, load_w, acc_w, report_w, timeout_w;
  logic to_hit, last_w;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    to_cnt_d   = '0;
    complete_d = complete_q;
    start_w    = 1'b0;
    clr_w      = 1'b0;
    load_w     = 1'b0;
    acc_w      = 1'b0;
    report_w   = 1'b0;
    timeout_w  = 1'b0;

    case (state_q)
      S_IDLE: begin
        complete_d = 1'b0;
        if (enable) begin
          clr_w   = 1'b1;
          load_w  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        start_w = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!mif.fsmDone)  state_d   = S_WAIT_DONE;
        else if (to_hit)   timeout_w = 1'b1;
        else               to_cnt_d  = to_cnt_q + TO_W'(1);
      end
      S_WAIT_DONE: begin
        if (mif.fsmDone)   state_d   = S_ACCUM;
        else if (to_hit)   timeout_w = 1'b1;
        else               to_cnt_d  = to_cnt_q + TO_W'(1);
      end
      S_ACCUM: begin
        acc_w = 1'b1;
        // Losing enable keeps this sample but abandons the average without reporting.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (last_w) begin
          state_d = S_REPORT;
        end else begin
          state_d   = S_WAIT_PERIOD;
          per_cnt_d = interval;
        end
      end
      S_REPORT: begin
        report_w   = 1'b1;
        complete_d = 1'b1;
        state_d    = S_WAIT_PERIOD;
        per_cnt_d  = interval;
      end
      S_WAIT_PERIOD: begin
        if (per_cnt_q == '0) begin
          if (!enable || complete_q) state_d = S_IDLE;
          else                       state_d = S_START;
        end else begin
          per_cnt_d = per_cnt_q - PERIOD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_w) begin
      clr_w     = 1'b1;
      state_d   = S_WAIT_PERIOD;
      per_cnt_d = interval;
    end

    error_d = timeout_w || (error_q && !flagClr);
  end

  always_ff @(posedge lfClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      per_cnt_q  <= '0;
      to_cnt_q   <= '0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      to_cnt_q   <= to_cnt_d;
      complete_q <= complete_d;
      error_q    <= error_d;
    end
  end

  temp_avg_acc #(
    .WIDTH        (WIDTH),
    .AVG_MAX_LOG2 (AVG_MAX_LOG2)
  ) u_acc (
    .clk         (lfClk),
    .rst_n       (rst_n),
    .clr_i       (clr_w),
    .load_i      (load_w),
    .log2_i      (clamp_log2(avgLog2, AVG_MAX_LOG2)),
    .acc_i       (acc_w),
    .sample_i    (mif.cycles),
    .report_i    (report_w),
    .th_high_i   (thHigh),
    .th_low_i    (thLow),
    .flag_clr_i  (flagClr),
    .last_o      (last_w),
    .avg_o       (mif.avg),
    .avg_valid_o (mif.avgValid),
    .flag_high_o (mif.flagHigh),
    .flag_low_o  (mif.flagLow)
  );

  // Decoded from the async-reset state register so reset drops start immediately.
  assign mif.start = start_w;
  assign mif.error = error_q;

endmodule

// File: tb/tb_temp_sampler.sv
// Self-checking bench for temp_sampler with a behavioural measurement FSM and an average scoreboard.
module tb_temp_sampler;
  import temp_pkg::*;

  localparam int WIDTH = 10;
  localparam int PERIOD_W = 16;

  logic                lfClk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic [PERIOD_W-1:0] interval = '0;
  logic [1:0]          avgLog2 = '0;
  logic [WIDTH-1:0]    thHigh = '1;
  logic [WIDTH-1:0]    thLow = '0;
  logic                flagClr = 1'b0;

  temp_sampler_if #(.WIDTH(WIDTH)) tif();

  temp_sampler #(.WIDTH(WIDTH), .PERIOD_W(PERIOD_W), .AVG_MAX_LOG2(3), .TIMEOUT(15)) dut (
    .lfClk(lfClk), .rst_n(rst_n), .enable(enable), .interval(interval), .avgLog2(avgLog2),
    .thHigh(thHigh), .thLow(thLow), .flagClr(flagClr), .mif(tif.master)
  );

  always #15 lfClk = ~lfClk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] cyc_q[$];
  int exp_q[$];
  bit hang_mode = 1'b0;

  // Measurement FSM model: done drops 2 cycles after start, result ready 4 cycles after start.
  int m_phase;
  bit m_busy, m_hang;
  logic [WIDTH-1:0] m_val;
  always @(negedge lfClk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      tif.fsmDone = 1'b1;
      tif.cycles = '0;
    end else if (tif.start) begin
      m_busy = 1'b1; m_phase = 0; m_hang = hang_mode;
      m_val = (cyc_q.size() != 0) ? cyc_q.pop_front() : '0;
    end else if (m_busy) begin
      m_phase++;
      if (!m_hang) begin
        if (m_phase == 2) tif.fsmDone = 1'b0;
        else if (m_phase == 4) begin tif.fsmDone = 1'b1; tif.cycles = m_val; m_busy = 1'b0; end
      end
    end
  end

  int cyc_n = 0, start_cnt = 0, start_wide = 0, avg_pulses = 0, last_start = 0, prev_start = 0;
  bit start_prev = 1'b0;
  always @(negedge lfClk) begin
    cyc_n++;
    if (tif.start) begin
      if (!start_prev) begin start_cnt++; prev_start = last_start; last_start = cyc_n; end
      else start_wide++;
    end
    start_prev = tif.start;
    if (tif.avgValid) avg_pulses++;
  end

  task automatic tick(); @(negedge lfClk); #1; endtask
  task automatic ticks(input int n); repeat (n) tick(); endtask

  task automatic wait_avg(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin tick(); if (tif.avgValid) ok = 1'b1; end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin tick(); if (tif.start) ok = 1'b1; end
  endtask

  task automatic test_reset();
    ticks(2);
    n_cmp++; if (tif.start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b want 0", tif.start); end
    n_cmp++; if (tif.avg !== '0) begin n_bad++; $display("FAIL rst_avg: got %0d want 0", tif.avg); end
    n_cmp++; if (tif.avgValid !== 1'b0) begin n_bad++; $display("FAIL rst_avgValid: got %b want 0", tif.avgValid); end
    n_cmp++; if ({tif.flagHigh, tif.flagLow, tif.error} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {tif.flagHigh, tif.flagLow, tif.error}); end
    @(posedge lfClk); #1 rst_n = 1'b1;
    ticks(5);
    n_cmp++; if (start_cnt !== 0) begin n_bad++; $display("FAIL idle_no_start: got %0d starts want 0", start_cnt); end
  endtask

  task automatic test_basic_avg();
    int s0, w0, p0, e; bit ok;
    avgLog2 = 2'd2; interval = 16'd3;
    for (int v = 100; v < 104; v++) cyc_q.push_back(WIDTH'(v));
    exp_q.push_back((100 + 101 + 102 + 103) / 4);
    s0 = start_cnt; w0 = start_wide; p0 = avg_pulses;
    enable = 1'b1;
    wait_avg(300, ok);
    enable = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_valid: no avgValid within budget"); end
    e = exp_q.pop_front();
    n_cmp++; if (tif.avg !== WIDTH'(e)) begin n_bad++; $display("FAIL basic_avg: got %0d want %0d", tif.avg, e); end
    ticks(30);
    n_cmp++; if (start_cnt - s0 !== 4) begin n_bad++; $display("FAIL basic_starts: got %0d want 4", start_cnt - s0); end
    n_cmp++; if (start_wide !== w0) begin n_bad++; $display("FAIL basic_start_width: got %0d extra cycles want 0", start_wide - w0); end
    n_cmp++; if (avg_pulses - p0 !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", avg_pulses - p0); end
  endtask

  task automatic test_single_sample();
    int e; bit ok;
    avgLog2 = 2'd0; interval = 16'd0;
    for (int k = 0; k < 3; k++) begin cyc_q.push_back(10'd1023); exp_q.push_back(1023); end
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_avg(100, ok);
      if (k == 2) enable = 1'b0;
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_valid_%0d: no avgValid within budget", k); end
      e = exp_q.pop_front();
      n_cmp++; if (tif.avg !== WIDTH'(e)) begin n_bad++; $display("FAIL single_avg_%0d: got %0d want %0d", k, tif.avg, e); end
      if (k > 0) begin
        n_cmp++; if (last_start - prev_start !== 9) begin n_bad++; $display("FAIL single_spacing_%0d: got %0d want 9", k, last_start - prev_start); end
      end
    end
    ticks(20);
  endtask

  task automatic test_thresholds();
    logic [WIDTH-1:0] vals[3] = '{10'd500, 10'd501, 10'd199};
    logic [1:0] flg[3] = '{2'b00, 2'b10, 2'b11};
    int e; bit ok;
    avgLog2 = 2'd0; interval = 16'd40; thHigh = 10'd500; thLow = 10'd200;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc_q.push_back(vals[i]); exp_q.push_back(int'(vals[i]));
      wait_avg(150, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL th_valid_%0d: no avgValid within budget", i); end
      e = exp_q.pop_front();
      n_cmp++; if (tif.avg !== WIDTH'(e)) begin n_bad++; $display("FAIL th_avg_%0d: got %0d want %0d", i, tif.avg, e); end
      n_cmp++; if ({tif.flagHigh, tif.flagLow} !== flg[i]) begin n_bad++; $display("FAIL th_flags_%0d: got %b want %b", i, {tif.flagHigh, tif.flagLow}, flg[i]); end
    end
    cyc_q.push_back(10'd600); exp_q.push_back(600);
    wait_start(150, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL th_clr_start: no start within budget"); end
    ticks(6);
    flagClr = 1'b1;
    tick();
    flagClr = 1'b0;
    enable = 1'b0;
    n_cmp++; if (tif.avgValid !== 1'b1) begin n_bad++; $display("FAIL th_clr_valid: got %b want 1", tif.avgValid); end
    e = exp_q.pop_front();
    n_cmp++; if (tif.avg !== WIDTH'(e)) begin n_bad++; $display("FAIL th_clr_avg: got %0d want %0d", tif.avg, e); end
    n_cmp++; if ({tif.flagHigh, tif.flagLow} !== 2'b10) begin n_bad++; $display("FAIL th_clr_flags: got %b want 10", {tif.flagHigh, tif.flagLow}); end
    ticks(60);
  endtask

  task automatic test_timeout();
    int s1, p0; bit ok;
    thHigh = '1; thLow = '0; avgLog2 = 2'd0; interval = 16'd5;
    flagClr = 1'b1; tick(); flagClr = 1'b0; tick();
    n_cmp++; if ({tif.flagHigh, tif.flagLow, tif.error} !== 3'b000) begin n_bad++; $display("FAIL to_preclear: got %b want 000", {tif.flagHigh, tif.flagLow, tif.error}); end
    hang_mode = 1'b1; p0 = avg_pulses;
    enable = 1'b1;
    wait_start(10, ok);
    s1 = cyc_n;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin tick(); if (tif.error) ok = 1'b1; end
    n_cmp++; if (!ok || (cyc_n - s1) !== 16) begin n_bad++; $display("FAIL to_error_time: seen=%b after %0d cycles want 16", ok, cyc_n - s1); end
    wait_start(40, ok);
    n_cmp++; if (!ok || (cyc_n - s1) !== 22) begin n_bad++; $display("FAIL to_restart: seen=%b after %0d cycles want 22", ok, cyc_n - s1); end
    enable = 1'b0; hang_mode = 1'b0;
    n_cmp++; if (avg_pulses !== p0) begin n_bad++; $display("FAIL to_no_valid: got %0d pulses want 0", avg_pulses - p0); end
    ticks(40);
    n_cmp++; if (dut.state_q !== S_IDLE) begin n_bad++; $display("FAIL to_idle: got state %0d want %0d", dut.state_q, S_IDLE); end
    flagClr = 1'b1; tick(); flagClr = 1'b0; tick();
    n_cmp++; if (tif.error !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b want 0", tif.error); end
  endtask

  task automatic test_enable_drop();
    int s0, p0; bit ok;
    avgLog2 = 2'd2; interval = 16'd3;
    cyc_q.push_back(10'd10); cyc_q.push_back(10'd20); cyc_q.push_back(10'd30); cyc_q.push_back(10'd40);
    s0 = start_cnt; p0 = avg_pulses;
    enable = 1'b1;
    wait_start(10, ok);
    wait_start(40, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL en_second_start: no start within budget"); end
    ticks(3);
    n_cmp++; if (dut.state_q !== S_WAIT_DONE) begin n_bad++; $display("FAIL en_in_wait_done: got state %0d want %0d", dut.state_q, S_WAIT_DONE); end
    enable = 1'b0;
    ticks(40);
    n_cmp++; if (start_cnt - s0 !== 2) begin n_bad++; $display("FAIL en_starts: got %0d want 2", start_cnt - s0); end
    n_cmp++; if (avg_pulses !== p0) begin n_bad++; $display("FAIL en_no_valid: got %0d pulses want 0", avg_pulses - p0); end
    n_cmp++; if (dut.state_q !== S_IDLE) begin n_bad++; $display("FAIL en_idle: got state %0d want %0d", dut.state_q, S_IDLE); end
    n_cmp++; if (cyc_q.size() !== 2 || tif.fsmDone !== 1'b1) begin n_bad++; $display("FAIL en_handshake: left %0d samples done=%b want 2 and 1", cyc_q.size(), tif.fsmDone); end
    while (cyc_q.size() != 0) void'(cyc_q.pop_front());
  endtask

  task automatic test_async_reset();
    int e, r0; bit ok;
    thHigh = '0; thLow = '0; avgLog2 = 2'd0; interval = 16'd60;
    cyc_q.push_back(10'd50); exp_q.push_back(50);
    enable = 1'b1;
    wait_avg(100, ok);
    e = exp_q.pop_front();
    n_cmp++; if (!ok || tif.avg !== WIDTH'(e) || tif.flagHigh !== 1'b1) begin n_bad++; $display("FAIL ar_pre: valid=%b avg=%0d high=%b want 1 %0d 1", ok, tif.avg, tif.flagHigh, e); end
    wait_start(100, ok);
    n_cmp++; if (!ok || tif.start !== 1'b1) begin n_bad++; $display("FAIL ar_start_high: seen=%b start=%b want 1", ok, tif.start); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (tif.start !== 1'b0 || tif.avgValid !== 1'b0) begin n_bad++; $display("FAIL ar_start_drop: start=%b avgValid=%b want 0 0", tif.start, tif.avgValid); end
    n_cmp++; if ({tif.flagHigh, tif.flagLow, tif.error} !== 3'b000 || tif.avg !== '0) begin n_bad++; $display("FAIL ar_clear: flags=%b avg=%0d want 000 0", {tif.flagHigh, tif.flagLow, tif.error}, tif.avg); end
    cyc_q.push_back(10'd77); exp_q.push_back(77);
    ticks(2);
    @(posedge lfClk); #1 rst_n = 1'b1;
    r0 = cyc_n;
    wait_start(10, ok);
    n_cmp++; if (!ok || (cyc_n - r0) !== 2) begin n_bad++; $display("FAIL ar_first_start: seen=%b after %0d cycles want 2", ok, cyc_n - r0); end
    wait_avg(50, ok);
    enable = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (!ok || tif.avg !== WIDTH'(e)) begin n_bad++; $display("FAIL ar_post_avg: valid=%b got %0d want %0d", ok, tif.avg, e); end
    ticks(70);
  endtask

  initial begin
    test_reset();
    test_basic_avg();
    test_single_sample();
    test_thresholds();
    test_timeout();
    test_enable_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
